// File: rtl/sd4_pp_stage_if.sv
// rtl/sd4_pp_stage_if.sv - beat-in/beat-out handshake bundle for the SD4 partial-product stage
interface sd4_pp_stage_if #(
    parameter int LANES  = 9,
    parameter int IMG_W  = 8,
    parameter int WGT_W  = 4,
    parameter int MANT_W = 4,
    parameter int EXP_W  = 5
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_last;
    logic [LANES*IMG_W-1:0]       image_in;
    logic [LANES*WGT_W-1:0]       weight_in;
    logic [EXP_W-1:0]             exp_bias_in;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_last;
    logic [LANES*(MANT_W+1)-1:0]  signed_pp;
    logic [LANES*EXP_W-1:0]       exp;
    logic [EXP_W-1:0]             exp_max;
    logic [EXP_W-1:0]             grp_exp_max;
    logic [7:0]                   grp_beats;
    logic [EXP_W-1:0]             exp_bias;

    modport slave (
        input  in_valid, in_last, image_in, weight_in, exp_bias_in, out_ready,
        output in_ready, out_valid, out_last, signed_pp, exp, exp_max,
               grp_exp_max, grp_beats, exp_bias
    );

    modport master (
        output in_valid, in_last, image_in, weight_in, exp_bias_in, out_ready,
        input  in_ready, out_valid, out_last, signed_pp, exp, exp_max,
               grp_exp_max, grp_beats, exp_bias
    );
endinterface

// File: rtl/sd4_pp_stage.sv
// rtl/sd4_pp_stage.sv - per-lane image x signed-power-of-two weight to {sign,mantissa,exp}, one-deep skid-free register stage with group exponent max
module sd4_pp_stage #(
    parameter int LANES  = 9,
    parameter int IMG_W  = 8,
    parameter int WGT_W  = 4,
    parameter int MANT_W = 4,
    parameter int EXP_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    sd4_pp_stage_if.slave        bus
);
    localparam int PP_W = MANT_W + 1;

    if ((2 ** EXP_W) - 1 < IMG_W + (2 ** (WGT_W - 1)) - 1) begin : g_bad_exp_w
        $error("sd4_pp_stage: EXP_W too narrow for IMG_W and WGT_W");
    end
    if (MANT_W > IMG_W) begin : g_bad_mant_w
        $error("sd4_pp_stage: MANT_W must not exceed IMG_W");
    end

    // Normalise the image so its leading one sits at the top; the mantissa is
    // then the top MANT_W bits, which pads with zeros on the right for small images.
    function automatic logic [PP_W+EXP_W-1:0] convert(input logic [IMG_W-1:0] img,
                                                      input logic [WGT_W-1:0] wgt);
        logic [EXP_W-1:0]  lead;
        logic [IMG_W-1:0]  norm;
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  e;
        lead = '0;
        for (int b = 0; b < IMG_W; b++) begin
            if (img[b]) lead = EXP_W'(b);
        end
        norm = img << (EXP_W'(IMG_W - 1) - lead);
        mant = norm[IMG_W-1 -: MANT_W];
        e    = lead + EXP_W'(wgt[WGT_W-2:0]) + EXP_W'(1);
        if (img == '0) begin
            convert = '0;
        end else begin
            convert = {wgt[WGT_W-1], mant, e};
        end
    endfunction

    logic [LANES*PP_W-1:0]  pp_c;
    logic [LANES*EXP_W-1:0] exp_c;
    logic [EXP_W-1:0]       exp_max_c;
    logic [PP_W+EXP_W-1:0]  lane_c;

    always_comb begin
        pp_c      = '0;
        exp_c     = '0;
        exp_max_c = '0;
        lane_c    = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_c = convert(bus.image_in[(LANES-1-i)*IMG_W +: IMG_W],
                             bus.weight_in[(LANES-1-i)*WGT_W +: WGT_W]);
            pp_c[(LANES-1-i)*PP_W +: PP_W]    = lane_c[PP_W+EXP_W-1 -: PP_W];
            exp_c[(LANES-1-i)*EXP_W +: EXP_W] = lane_c[EXP_W-1:0];
            if (lane_c[EXP_W-1:0] > exp_max_c) exp_max_c = lane_c[EXP_W-1:0];
        end
    end

    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [LANES*PP_W-1:0]  signed_pp_q, signed_pp_d;
    logic [LANES*EXP_W-1:0] exp_q, exp_d;
    logic [EXP_W-1:0]       exp_max_q, exp_max_d;
    logic [EXP_W-1:0]       grp_exp_max_q, grp_exp_max_d;
    logic [7:0]             grp_beats_q, grp_beats_d;
    logic [EXP_W-1:0]       exp_bias_q, exp_bias_d;
    logic [EXP_W-1:0]       acc_q, acc_d;
    logic [7:0]             cnt_q, cnt_d;

    logic             in_ready_c;
    logic             in_fire;
    logic [EXP_W-1:0] grp_max_c;
    logic [7:0]       grp_beats_c;

    // Ready is forced high in reset so upstream never stalls on a dead stage.
    assign in_ready_c  = rst | ~out_valid_q | bus.out_ready;
    assign in_fire     = bus.in_valid & in_ready_c & ~rst;
    assign grp_max_c   = (acc_q > exp_max_c) ? acc_q : exp_max_c;
    assign grp_beats_c = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        signed_pp_d   = signed_pp_q;
        exp_d         = exp_q;
        exp_max_d     = exp_max_q;
        grp_exp_max_d = grp_exp_max_q;
        grp_beats_d   = grp_beats_q;
        exp_bias_d    = exp_bias_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        if (in_fire) begin
            out_valid_d   = 1'b1;
            out_last_d    = bus.in_last;
            signed_pp_d   = pp_c;
            exp_d         = exp_c;
            exp_max_d     = exp_max_c;
            grp_exp_max_d = grp_max_c;
            grp_beats_d   = grp_beats_c;
            exp_bias_d    = bus.exp_bias_in;
            acc_d         = bus.in_last ? '0 : grp_max_c;
            cnt_d         = bus.in_last ? '0 : grp_beats_c;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            signed_pp_q   <= '0;
            exp_q         <= '0;
            exp_max_q     <= '0;
            grp_exp_max_q <= '0;
            grp_beats_q   <= '0;
            exp_bias_q    <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            signed_pp_q   <= signed_pp_d;
            exp_q         <= exp_d;
            exp_max_q     <= exp_max_d;
            grp_exp_max_q <= grp_exp_max_d;
            grp_beats_q   <= grp_beats_d;
            exp_bias_q    <= exp_bias_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_last    = out_last_q;
    assign bus.signed_pp   = signed_pp_q;
    assign bus.exp         = exp_q;
    assign bus.exp_max     = exp_max_q;
    assign bus.grp_exp_max = grp_exp_max_q;
    assign bus.grp_beats   = grp_beats_q;
    assign bus.exp_bias    = exp_bias_q;
endmodule

// File: tb/tb_sd4_pp_stage.sv
// tb/tb_sd4_pp_stage.sv - directed scoreboard bench for sd4_pp_stage at default parameters
module tb_sd4_pp_stage;
    localparam int LANES = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sd4_pp_stage_if bus ();
    sd4_pp_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [44:0] pp;
        logic [44:0] ex;
        logic [4:0]  emax;
        logic [4:0]  gmax;
        logic [7:0]  gb;
        logic [4:0]  bias;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    beat_t       mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    logic [4:0]  m_acc = '0;
    logic [7:0]  m_cnt = '0;
    logic [44:0] snap_pp;
    logic [7:0]  snap_gb;
    logic [4:0]  snap_gmax;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void lane_ref(input logic [7:0] img, input logic [3:0] w,
                                     output logic [4:0] pp, output logic [4:0] ex);
        int lead = -1;
        for (int b = 7; b >= 0; b--) if (img[b] && lead < 0) lead = b;
        pp = '0;
        ex = '0;
        if (lead >= 0) begin
            ex    = 5'(lead + int'(w[2:0]) + 1);
            pp[4] = w[3];
            for (int i = 0; i < 4; i++) begin
                if (lead - i >= 0) pp[3-i] = img[lead-i];
            end
        end
    endfunction

    task automatic send(input logic [71:0] img, input logic [35:0] wgt,
                        input logic last, input logic [4:0] bias);
        beat_t      e;
        logic [4:0] p, x;
        bit         done = 0;
        e.emax = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_ref(img[(LANES-1-i)*8 +: 8], wgt[(LANES-1-i)*4 +: 4], p, x);
            e.pp[(LANES-1-i)*5 +: 5] = p;
            e.ex[(LANES-1-i)*5 +: 5] = x;
            if (x > e.emax) e.emax = x;
        end
        e.bias = bias;
        e.last = last;
        bus.image_in    = img;
        bus.weight_in   = wgt;
        bus.in_last     = last;
        bus.exp_bias_in = bias;
        bus.in_valid    = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.gmax = (m_acc > e.emax) ? m_acc : e.emax;
                e.gb   = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
                m_acc  = last ? 5'd0 : e.gmax;
                m_cnt  = last ? 8'd0 : e.gb;
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        check({tag, "_out_last"}, {63'd0, bus.out_last}, 64'd0);
        check({tag, "_signed_pp"}, {19'd0, bus.signed_pp}, 64'd0);
        check({tag, "_exp"}, {19'd0, bus.exp}, 64'd0);
        check({tag, "_exp_max"}, {59'd0, bus.exp_max}, 64'd0);
        check({tag, "_grp_exp_max"}, {59'd0, bus.grp_exp_max}, 64'd0);
        check({tag, "_grp_beats"}, {56'd0, bus.grp_beats}, 64'd0);
        check({tag, "_exp_bias"}, {59'd0, bus.exp_bias}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", {63'd0, bus.out_valid}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_signed_pp", {19'd0, bus.signed_pp}, {19'd0, mon_e.pp});
                check("sb_exp", {19'd0, bus.exp}, {19'd0, mon_e.ex});
                check("sb_exp_max", {59'd0, bus.exp_max}, {59'd0, mon_e.emax});
                check("sb_grp_exp_max", {59'd0, bus.grp_exp_max}, {59'd0, mon_e.gmax});
                check("sb_grp_beats", {56'd0, bus.grp_beats}, {56'd0, mon_e.gb});
                check("sb_exp_bias", {59'd0, bus.exp_bias}, {59'd0, mon_e.bias});
                check("sb_out_last", {63'd0, bus.out_last}, {63'd0, mon_e.last});
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_last     = 1'b0;
        bus.image_in    = {9{8'hFF}};
        bus.weight_in   = {9{4'h7}};
        bus.exp_bias_in = 5'd17;
        bus.out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("reset_discard", {63'd0, bus.out_valid}, 64'd0);
        @(posedge clk);
        #1;

        send({8'h96, 64'd0}, {4'b1010, 32'd0}, 1'b1, 5'd3);
        check("v023_pp", {59'd0, bus.signed_pp[44 -: 5]}, 64'h19);
        check("v023_exp", {59'd0, bus.exp[44 -: 5]}, 64'd10);
        check("v023_exp_max", {59'd0, bus.exp_max}, 64'd10);
        check("v023_grp_beats", {56'd0, bus.grp_beats}, 64'd1);
        send({8'h03, 64'd0}, {4'b0011, 32'd0}, 1'b1, 5'd0);
        check("v024_pp", {59'd0, bus.signed_pp[44 -: 5]}, 64'h0C);
        check("v024_exp", {59'd0, bus.exp[44 -: 5]}, 64'd5);
        send({8'h00, 64'd0}, {4'b1111, 32'd0}, 1'b1, 5'd0);
        check("v024_zero_pp", {59'd0, bus.signed_pp[44 -: 5]}, 64'd0);
        check("v024_zero_exp", {59'd0, bus.exp[44 -: 5]}, 64'd0);

        send({8'h08, 64'd0}, {4'h0, 32'd0}, 1'b0, 5'd1);
        check("grp_b1_max", {59'd0, bus.grp_exp_max}, 64'd4);
        check("grp_b1_beats", {56'd0, bus.grp_beats}, 64'd1);
        send({8'h80, 64'd0}, {4'h1, 32'd0}, 1'b0, 5'd2);
        check("grp_b2_max", {59'd0, bus.grp_exp_max}, 64'd9);
        check("grp_b2_beats", {56'd0, bus.grp_beats}, 64'd2);
        send({8'h20, 64'd0}, {4'h0, 32'd0}, 1'b1, 5'd3);
        check("grp_b3_max", {59'd0, bus.grp_exp_max}, 64'd9);
        check("grp_b3_beats", {56'd0, bus.grp_beats}, 64'd3);
        send({8'h02, 64'd0}, {4'h0, 32'd0}, 1'b1, 5'd4);
        check("grp_new_max", {59'd0, bus.grp_exp_max}, 64'd2);
        check("grp_new_beats", {56'd0, bus.grp_beats}, 64'd1);

        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send({8'h40, 64'd0}, {4'h2, 32'd0}, 1'b0, 5'd5);
        bus.image_in    = {8'h01, 64'd0};
        bus.weight_in   = 36'd0;
        bus.in_last     = 1'b1;
        bus.exp_bias_in = 5'd6;
        bus.in_valid    = 1'b1;
        snap_pp   = bus.signed_pp;
        snap_gb   = bus.grp_beats;
        snap_gmax = bus.grp_exp_max;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
            check("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
            check("stall_pp_hold", {19'd0, bus.signed_pp}, {19'd0, snap_pp});
            check("stall_gb_hold", {56'd0, bus.grp_beats}, {56'd0, snap_gb});
            check("stall_gmax_hold", {59'd0, bus.grp_exp_max}, {59'd0, snap_gmax});
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send({8'h01, 64'd0}, 36'd0, 1'b1, 5'd6);
        check("stall_after_max", {59'd0, bus.grp_exp_max}, 64'd9);
        check("stall_after_beats", {56'd0, bus.grp_beats}, 64'd2);

        for (int n = 0; n < 20; n++) begin
            send({$urandom, $urandom, 8'($urandom)}, {$urandom, 4'($urandom)},
                 1'($urandom_range(0, 3) == 0), 5'($urandom));
        end
        send({$urandom, $urandom, 8'($urandom)}, {$urandom, 4'($urandom)}, 1'b1, 5'd0);

        for (int n = 0; n < 300; n++) begin
            send({$urandom, $urandom, 8'($urandom)}, {$urandom, 4'($urandom)},
                 1'b0, 5'($urandom));
        end
        check("sat_beats", {56'd0, bus.grp_beats}, 64'd255);
        send({8'h01, 64'd0}, 36'd0, 1'b1, 5'd0);
        check("sat_last_beats", {56'd0, bus.grp_beats}, 64'd255);

        send({8'h10, 64'd0}, 36'd0, 1'b0, 5'd7);
        send({8'h20, 64'd0}, 36'd0, 1'b0, 5'd8);
        bus.out_ready   = 1'b0;
        bus.image_in    = {9{8'h55}};
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        sb.delete();
        m_acc = '0;
        m_cnt = '0;
        @(posedge clk);
        #1;
        check_zero("midrst");
        check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("midrst_discard", {63'd0, bus.out_valid}, 64'd0);
        @(posedge clk);
        #1;
        send({8'h10, 64'd0}, 36'd0, 1'b1, 5'd9);
        check("midrst_first_beats", {56'd0, bus.grp_beats}, 64'd1);
        check("midrst_first_max", {59'd0, bus.grp_exp_max}, 64'd5);

        for (int t = 0; t < 10 && sb.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
